fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 143 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains bytes from an upstream FIFO and sends each one as an 8N1 UART frame, LSB first.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit after the data bits (8E1).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] data_in,
    output logic       rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    // state  | meaning
    // IDLE   | line idle high, sampling empty
    // FETCH  | one-cycle read strobe to the FIFO
    // LATCH  | FIFO read data valid, captured into the shift register
    // START  | start bit (0)
    // DATA   | eight data bits, LSB first
    // PARITY | even parity over the data byte (parity build only)
    // STOP   | stop bit (1); tx_done on its last cycle

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, START, DATA, STOP
    } state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic             tx_next;
    logic             bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_q;
`endif

    assign bit_end = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (!empty) next_state = FETCH;
            FETCH: next_state = LATCH;
            LATCH: next_state = START;
            START: if (bit_end) next_state = DATA;
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: if (bit_end) next_state = STOP;
`endif
            STOP:  if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // tx is registered from the value the line must carry in the next state.
    always_comb begin
        rd      = (state == FETCH);
        busy    = (state != IDLE);
        tx_done = (state == STOP) && bit_end;
        case (next_state)
            START:  tx_next = 1'b0;
            DATA:   tx_next = shreg_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: tx_next = parity_q;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_comb begin
        shreg_next = shreg;
        if (state == LATCH) begin
            shreg_next = data_in;
        end else if ((state == DATA) && bit_end) begin
            shreg_next = {1'b0, shreg[7:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            tx    <= tx_next;
            shreg <= shreg_next;
            case (state)
`ifdef FIFO_UART_TX_PARITY_EN
                START, DATA, PARITY, STOP: cnt <= bit_end ? CNT_LOAD : cnt - CNT_W'(1);
`else
                START, DATA, STOP: cnt <= bit_end ? CNT_LOAD : cnt - CNT_W'(1);
`endif
                default: cnt <= CNT_LOAD;
            endcase
            if (state == DATA) begin
                if (bit_end) bit_idx <= bit_idx + 3'd1;
            end else begin
                bit_idx <= '0;
            end
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (state == LATCH) begin
            parity_q <= ^data_in;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: frames are predicted from a byte list and compared cycle by cycle.
// Build with FIFO_UART_TX_PARITY_EN defined to check the parity variant.
module tb_fifo_uart_tx;

    localparam int N = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_GAP = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty;
    logic [7:0] data_in;
    logic       rd;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int total = 0;
    int bad   = 0;

    byte unsigned fifo_q[$];
    logic tx_log[$];
    logic rd_log[$];
    logic done_log[$];
    logic busy_log[$];
    bit   toggle_en = 1'b0;
    int   tog_lo = 0;
    int   tog_hi = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .empty   (empty),
        .data_in (data_in),
        .rd      (rd),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle, then emulate the FIFO's registered read.
    task automatic tick();
        bit do_pop;
        @(negedge clk);
        tx_log.push_back(tx);
        rd_log.push_back(rd);
        done_log.push_back(tx_done);
        busy_log.push_back(busy);
        do_pop = rd && (fifo_q.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop) data_in = fifo_q.pop_front();
        cyc++;
        if (toggle_en && (cyc >= tog_lo) && (cyc <= tog_hi))
            empty = 1'($urandom_range(0, 1));
        else
            empty = (fifo_q.size() == 0);
    endtask

    function automatic logic frame_bit(input byte unsigned b, input int k);
        logic [7:0] v;
        v = b;
        if (k == 0) return 1'b0;
        if (k <= 8) return v[k-1];
        if (k == NBITS - 1) return 1'b1;
        return ^v;
    endfunction

    task automatic clear_logs();
        tx_log.delete();
        rd_log.delete();
        done_log.delete();
        busy_log.delete();
    endtask

    task automatic run(input byte unsigned bytes[$], input bit tog, input string tag);
        int   ncyc;
        int   t;
        int   s;
        int   e;
        int   n_tx;
        int   n_rd;
        int   n_done;
        int   n_busy;
        int   f_tx;
        int   rd_cnt;
        int   done_cnt;
        logic exp_tx[$];
        logic exp_rd[$];
        logic exp_done[$];
        logic exp_busy[$];
        ncyc = bytes.size() * (FRAME_GAP + NBITS * N) + 8;
        clear_logs();
        foreach (bytes[i]) fifo_q.push_back(bytes[i]);
        cyc       = 0;
        tog_lo    = 1;
        tog_hi    = 2 + NBITS * N;
        toggle_en = tog;
        empty     = 1'b0;
        repeat (ncyc) tick();
        toggle_en = 1'b0;

        for (int i = 0; i < ncyc; i++) begin
            exp_tx.push_back(1'b1);
            exp_rd.push_back(1'b0);
            exp_done.push_back(1'b0);
            exp_busy.push_back(1'b0);
        end
        t = 0;
        foreach (bytes[i]) begin
            s = t + FRAME_GAP;
            e = s + NBITS * N - 1;
            exp_rd[t+1] = 1'b1;
            for (int c = t + 1; c <= e; c++) exp_busy[c] = 1'b1;
            for (int k = 0; k < NBITS; k++)
                for (int j = 0; j < N; j++)
                    exp_tx[s + k*N + j] = frame_bit(bytes[i], k);
            exp_done[e] = 1'b1;
            t = e + 1;
        end

        n_tx = 0; n_rd = 0; n_done = 0; n_busy = 0; f_tx = -1;
        rd_cnt = 0; done_cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (tx_log[i] !== exp_tx[i]) begin
                n_tx++;
                if (f_tx < 0) f_tx = i;
            end
            if (rd_log[i] !== exp_rd[i]) n_rd++;
            if (done_log[i] !== exp_done[i]) n_done++;
            if (busy_log[i] !== exp_busy[i]) n_busy++;
            if (rd_log[i] === 1'b1) rd_cnt++;
            if (done_log[i] === 1'b1) done_cnt++;
        end
        chk($sformatf("%s_tx_mismatch_cycles(first@%0d)", tag, f_tx), n_tx, 0);
        chk({tag, "_rd_mismatch_cycles"}, n_rd, 0);
        chk({tag, "_done_mismatch_cycles"}, n_done, 0);
        chk({tag, "_busy_mismatch_cycles"}, n_busy, 0);
        chk({tag, "_rd_pulses"}, rd_cnt, bytes.size());
        chk({tag, "_done_pulses"}, done_cnt, bytes.size());
    endtask

    initial begin
        byte unsigned bq[$];
        int   a5_bits[NBITS];
        int   nm;
        int   rd_cnt;
        int   low_cnt;

        rst     = 1'b1;
        empty   = 1'b1;
        data_in = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_tx", tx, 1);
        chk("reset_rd", rd, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", tx_done, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single 0xA5, plus a literal check of the serial bit sequence.
        bq.delete(); bq.push_back(8'hA5);
        run(bq, 1'b0, "a5");
`ifdef FIFO_UART_TX_PARITY_EN
        a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
        nm = 0;
        for (int k = 0; k < NBITS; k++)
            for (int j = 0; j < N; j++)
                if (tx_log[FRAME_GAP + k*N + j] !== 1'(a5_bits[k])) nm++;
        chk("a5_literal_bits", nm, 0);
        chk("a5_done_last_cycle", done_log[FRAME_GAP + NBITS*N - 1], 1);
        chk("a5_busy_after", busy_log[FRAME_GAP + NBITS*N], 0);

        bq.delete(); bq.push_back(8'h07);
        run(bq, 1'b0, "b07");

        bq.delete(); bq.push_back(8'h00); bq.push_back(8'hFF); bq.push_back(8'h55);
        run(bq, 1'b0, "three");

        for (int it = 0; it < 4; it++) begin
            bq.delete();
            repeat ($urandom_range(1, 3)) bq.push_back(8'($urandom));
            run(bq, 1'b0, $sformatf("rand%0d", it));
        end

        // empty wiggles while a frame is in flight
        for (int it = 0; it < 3; it++) begin
            bq.delete(); bq.push_back(8'($urandom));
            run(bq, 1'b1, $sformatf("toggle%0d", it));
        end

        // Reset during data bit 3 of 0x3C
        clear_logs();
        fifo_q.push_back(8'h3C);
        cyc   = 0;
        empty = 1'b0;
        repeat (FRAME_GAP + 4*N + 1) tick();
        chk("abort_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_rd", rd, 0);
        chk("abort_done", tx_done, 0);
        @(posedge clk);
        #3;
        rst   = 1'b0;
        empty = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        repeat (100) tick();
        rd_cnt = 0; low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (rd_log[i] !== 1'b0) rd_cnt++;
            if (tx_log[i] !== 1'b1) low_cnt++;
        end
        chk("post_abort_rd_cycles", rd_cnt, 0);
        chk("post_abort_tx_low_cycles", low_cnt, 0);

        // Normal operation resumes after the abort
        bq.delete(); bq.push_back(8'($urandom));
        run(bq, 1'b0, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
